// File: rtl/sa_host_seq.sv
// Host-side sequencer for the systolic array top: loads weights/activations, kicks the array,
// polls for completion and streams results out. Optional SA_SEQ_OBUF_CLR_EN adds an output-buffer clear.
module sa_host_seq #(
    parameter int unsigned MAC_W = 19,
    parameter int unsigned X_W   = 8,
    parameter int unsigned N_ENT = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [X_W-1:0]   in_data_i,
    output logic [7:0]       addr_o,
    output logic [31:0]      data_o,
    output logic             wr_vo,
    input  logic [MAC_W-1:0] rdata_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [MAC_W-1:0] res_data_o,
    output logic             res_last_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 6;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_ENT - 1);
    localparam logic [ADDR_W-1:0] CLR_ADDR  = 8'h80;
    localparam logic [ADDR_W-1:0] GO_ADDR   = 8'hC0;
    localparam logic [DATA_W-1:0] GO_DATA   = 32'h0000_0001;

    typedef enum logic [3:0] {
        IDLE,
        LOAD_W,
        LOAD_X,
`ifdef SA_SEQ_OBUF_CLR_EN
        CLR,
`endif
        START,
        SETTLE,
        POLL,
        RD_ADDR,
        RD_CAP,
        OUT
    } state_t;

`ifdef SA_SEQ_OBUF_CLR_EN
    localparam state_t POST_LOAD = CLR;
`else
    localparam state_t POST_LOAD = START;
`endif

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               settle_q, settle_d;

    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               wr_q, wr_d;
    logic               in_ready_q;
    logic               res_valid_q;
    logic [MAC_W-1:0]   res_data_q, res_data_d;
    logic               res_last_q;
    logic               busy_q;
    logic               done_q, done_d;

    logic               in_fire;
    logic               res_fire;

    assign in_fire  = in_valid_i & in_ready_q;
    assign res_fire = res_valid_q & res_ready_i;

    // State register and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            settle_q    <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            wr_q        <= 1'b0;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            settle_q    <= settle_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            wr_q        <= wr_d;
            in_ready_q  <= (state_d == LOAD_W) || (state_d == LOAD_X);
            res_valid_q <= (state_d == OUT);
            res_data_q  <= res_data_d;
            res_last_q  <= (state_d == OUT) && (idx_d == LAST_IDX);
            busy_q      <= (state_d != IDLE);
            done_q      <= done_d;
        end
    end

    // Next-state and next-output decode; bus outputs appear one cycle after their decode
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        settle_d   = settle_q;
        addr_d     = '0;
        data_d     = '0;
        wr_d       = 1'b0;
        res_data_d = res_data_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = LOAD_W;
                    idx_d   = '0;
                end
            end

            LOAD_W, LOAD_X: begin
                if (in_fire) begin
                    wr_d   = 1'b1;
                    addr_d = {((state_q == LOAD_X) ? 2'b01 : 2'b00), idx_q};
                    data_d = DATA_W'(in_data_i);
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = (state_q == LOAD_W) ? LOAD_X : POST_LOAD;
                    end else begin
                        idx_d = IDX_W'(idx_q + 1'b1);
                    end
                end
            end

`ifdef SA_SEQ_OBUF_CLR_EN
            CLR: begin
                wr_d    = 1'b1;
                addr_d  = CLR_ADDR;
                state_d = START;
            end
`endif

            START: begin
                wr_d     = 1'b1;
                addr_d   = GO_ADDR;
                data_d   = GO_DATA;
                settle_d = 1'b0;
                state_d  = SETTLE;
            end

            // Status read is not trusted until the array has seen the go write
            SETTLE: begin
                if (settle_q) begin
                    settle_d = 1'b0;
                    state_d  = POLL;
                end else begin
                    settle_d = 1'b1;
                end
            end

            POLL: begin
                if (rdata_i[0]) begin
                    idx_d   = '0;
                    state_d = RD_ADDR;
                end
            end

            RD_ADDR: begin
                addr_d  = {2'b10, idx_q};
                state_d = RD_CAP;
            end

            RD_CAP: begin
                addr_d     = addr_q;
                res_data_d = rdata_i;
                state_d    = OUT;
            end

            OUT: begin
                addr_d = addr_q;
                if (res_fire) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d   = IDX_W'(idx_q + 1'b1);
                        state_d = RD_ADDR;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign addr_o      = addr_q;
    assign data_o      = data_q;
    assign wr_vo       = wr_q;
    assign in_ready_o  = in_ready_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign res_last_o  = res_last_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_sa_host_seq.sv
// Scoreboard bench for sa_host_seq: stimulus pushes expected writes/results, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_sa_host_seq;

    localparam int unsigned MAC_W  = 19;
    localparam int unsigned X_W    = 8;
    localparam int unsigned N_ENT  = 64;
    localparam int unsigned N_LOAD = 2 * N_ENT;
`ifdef SA_SEQ_OBUF_CLR_EN
    localparam int unsigned N_WR = N_LOAD + 2;
`else
    localparam int unsigned N_WR = N_LOAD + 1;
`endif

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
        logic        cd;
    } wexp_t;

    typedef struct packed {
        logic [MAC_W-1:0] d;
        logic             last;
    } rexp_t;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             start_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [X_W-1:0]   in_data_i;
    logic [7:0]       addr_o;
    logic [31:0]      data_o;
    logic             wr_vo;
    logic [MAC_W-1:0] rdata_i;
    logic             res_valid_o;
    logic             res_ready_i;
    logic [MAC_W-1:0] res_data_o;
    logic             res_last_o;
    logic             busy_o;
    logic             done_o;

    sa_host_seq #(.MAC_W(MAC_W), .X_W(X_W), .N_ENT(N_ENT)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .addr_o      (addr_o),
        .data_o      (data_o),
        .wr_vo       (wr_vo),
        .rdata_i     (rdata_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_data_o  (res_data_o),
        .res_last_o  (res_last_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    wexp_t exp_wr[$];
    rexp_t exp_res[$];

    bit mon_en = 1'b0;
    int wr_cnt, res_cnt, done_cnt;
    bit job_done, c0_seen;
    bit hold, last_xfer;
    logic [MAC_W-1:0] hold_data;
    logic [7:0]       hold_addr;
    int poll_cnt;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Array-top model: status bit rises 30+ cycles after the go write; reads return 0x1000+index
    always @(posedge clk) begin
        if (rst_i) poll_cnt <= 0;
        else if (wr_vo === 1'b1 && addr_o == 8'hC0) poll_cnt <= 0;
        else if (poll_cnt < 1000) poll_cnt <= poll_cnt + 1;
    end

    always_comb begin
        if (addr_o[7:6] == 2'b10) rdata_i = MAC_W'(32'h1000 + 32'(addr_o[5:0]));
        else                      rdata_i = (poll_cnt > 30) ? MAC_W'(1) : '0;
    end

    // Monitor: pops and compares whenever the DUT presents a write, a result beat or done
    always @(negedge clk) begin
        if (mon_en) begin
            if (wr_vo === 1'b1) begin
                wexp_t w;
                wr_cnt++;
                if (addr_o == 8'hC0) c0_seen = 1'b1;
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write_addr", 64'(addr_o), 64'hFFFF);
                end else begin
                    w = exp_wr.pop_front();
                    chk("wr_addr", 64'(addr_o), 64'(w.a));
                    if (w.cd) chk("wr_data", 64'(data_o), 64'(w.d));
                end
            end else begin
                chk("idle_data_zero", 64'(data_o), 64'd0);
            end

            if (hold) begin
                chk("stall_valid", 64'(res_valid_o), 64'd1);
                chk("stall_data", 64'(res_data_o), 64'(hold_data));
                chk("stall_addr", 64'(addr_o), 64'(hold_addr));
            end
            hold      = (res_valid_o === 1'b1) && (res_ready_i === 1'b0);
            hold_data = res_data_o;
            hold_addr = addr_o;

            if (done_o === 1'b1) begin
                done_cnt++;
                chk("done_after_last", 64'(last_xfer), 64'd1);
                job_done = 1'b1;
            end

            last_xfer = 1'b0;
            if (res_valid_o === 1'b1 && res_ready_i === 1'b1) begin
                rexp_t r;
                res_cnt++;
                last_xfer = res_last_o;
                if (exp_res.size() == 0) begin
                    chk("unexpected_result", 64'(res_data_o), 64'hFFFF_FFFF);
                end else begin
                    r = exp_res.pop_front();
                    chk("res_data", 64'(res_data_o), 64'(r.d));
                    chk("res_last", 64'(res_last_o), 64'(r.last));
                end
            end
        end
    end

    task automatic check_zero(string tag);
        chk({tag, "_addr"},      64'(addr_o), 64'd0);
        chk({tag, "_data"},      64'(data_o), 64'd0);
        chk({tag, "_wr"},        64'(wr_vo), 64'd0);
        chk({tag, "_in_ready"},  64'(in_ready_o), 64'd0);
        chk({tag, "_res_valid"}, 64'(res_valid_o), 64'd0);
        chk({tag, "_res_data"},  64'(res_data_o), 64'd0);
        chk({tag, "_res_last"},  64'(res_last_o), 64'd0);
        chk({tag, "_done"},      64'(done_o), 64'd0);
        chk({tag, "_busy"},      64'(busy_o), 64'd0);
    endtask

    // vmode: 0 back-to-back ramp, 1 valid every other cycle, 2 random valid/ready
    task automatic run_job(input int vmode, input bit stall5, input bit poke, input int rst_at);
        logic [X_W-1:0] d[N_LOAD];
        int k, cyc, stall, pk;
        bit acc;
        for (int i = 0; i < int'(N_LOAD); i++) d[i] = (vmode == 0) ? X_W'(i) : X_W'($urandom);
        for (int i = 0; i < int'(N_LOAD); i++) exp_wr.push_back('{a: 8'(i), d: 32'(d[i]), cd: 1'b1});
`ifdef SA_SEQ_OBUF_CLR_EN
        exp_wr.push_back('{a: 8'h80, d: 32'd0, cd: 1'b1});
`endif
        exp_wr.push_back('{a: 8'hC0, d: 32'd0, cd: 1'b0});
        for (int i = 0; i < int'(N_ENT); i++)
            exp_res.push_back('{d: MAC_W'(32'h1000 + i), last: (i == int'(N_ENT) - 1)});
        wr_cnt = 0; res_cnt = 0; done_cnt = 0; job_done = 1'b0; c0_seen = 1'b0;

        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;

        k = 0; cyc = 0;
        while (k < int'(N_LOAD) && cyc < 4000 && !(rst_at > 0 && k == rst_at)) begin
            case (vmode)
                0:       in_valid_i = 1'b1;
                1:       in_valid_i = ((cyc % 2) == 0);
                default: in_valid_i = ($urandom % 3) != 0;
            endcase
            in_data_i = d[k];
            @(negedge clk);
            acc = in_valid_i && in_ready_o;
            @(posedge clk); #1;
            if (acc) k++;
            cyc++;
        end
        in_valid_i = 1'b0;

        if (rst_at > 0) begin
            rst_i = 1'b1;
            @(posedge clk); #1;
            check_zero("rst_mid");
            rst_i = 1'b0;
            exp_wr.delete();
            exp_res.delete();
            repeat (20) @(posedge clk);
            #1;
            chk("rst_stays_idle", 64'(busy_o), 64'd0);
            chk("rst_write_count", 64'(wr_cnt), 64'(rst_at));
            return;
        end

        chk("load_beats", 64'(k), 64'(N_LOAD));
        cyc = 0; stall = 0; pk = -1;
        while (!job_done && cyc < 5000) begin
            if (stall5 && res_valid_o && res_cnt == 5 && stall < 10) begin
                res_ready_i = 1'b0;
                stall++;
            end else begin
                res_ready_i = (vmode == 2) ? (($urandom % 4) != 0) : 1'b1;
            end
            if (poke) begin
                if (c0_seen && pk < 0) pk = 0;
                else if (pk >= 0 && pk < 8) pk++;
                start_i = (pk == 6);
            end
            @(posedge clk); #1;
            cyc++;
        end
        start_i = 1'b0;
        res_ready_i = 1'b0;
        chk("job_completed", 64'(job_done), 64'd1);
        repeat (2) @(negedge clk);
        #1;
        chk("write_count", 64'(wr_cnt), 64'(N_WR));
        chk("result_count", 64'(res_cnt), 64'(N_ENT));
        chk("done_pulses", 64'(done_cnt), 64'd1);
        chk("wr_queue_left", 64'(exp_wr.size()), 64'd0);
        chk("res_queue_left", 64'(exp_res.size()), 64'd0);
        chk("busy_after_job", 64'(busy_o), 64'd0);
        if (stall5) chk("stall_cycles", 64'(stall), 64'd10);
        if (poke) chk("poke_issued", 64'(pk >= 6), 64'd1);
        exp_wr.delete();
        exp_res.delete();
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; res_ready_i = 1'b0;
        hold = 1'b0; last_xfer = 1'b0; hold_data = '0; hold_addr = '0;
        wr_cnt = 0; res_cnt = 0; done_cnt = 0; job_done = 1'b0; c0_seen = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_i = 1'b0;
        mon_en = 1'b1;

        run_job(0, 1'b0, 1'b0, 0);
        run_job(1, 1'b0, 1'b0, 0);
        run_job(2, 1'b1, 1'b1, 0);
        run_job(2, 1'b0, 1'b0, int'(N_ENT) + 20);
        run_job(0, 1'b0, 1'b0, 0);
        run_job(2, 1'b1, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2ms;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

endmodule
